// File: rtl/j_clkdiv_cnt.sv
// j_clkdiv_cnt: programmable 6-bit divide counter with wrap tick, phase toggle and overrun recovery.
// Build option J_CLKDIV_SHADOW_EN defers ratio writes to period boundaries through a shadow register.
module j_clkdiv_cnt #(
   parameter logic [5:0] RESET_RATIO = 6'd63
) (
   input  logic       clk,
   input  logic       resetl,
   input  logic       en,
   input  logic       wr,
   input  logic [5:0] din,
   output logic [5:0] cnt,
   output logic [5:0] ratio,
   output logic       tick,
   output logic       phase,
   output logic       ovr
);

   logic [5:0] cnt_q;
   logic [5:0] cnt_d;
   logic [5:0] ratio_q;
   logic [5:0] ratio_d;
   logic       tick_q;
   logic       tick_d;
   logic       phase_q;
   logic       phase_d;
   logic       ovr_q;
   logic       ovr_d;
   logic       overrun;
   logic       wrap;

   // Both decisions use the ratio already registered; a write in this cycle lands afterwards.
   assign overrun = (cnt_q > ratio_q);
   assign wrap    = (cnt_q == ratio_q);

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      tick_d  = 1'b0;
      ovr_d   = 1'b0;
      if (en) begin
         if (overrun) begin
            cnt_d = 6'd0;
            ovr_d = 1'b1;
         end else if (wrap) begin
            cnt_d   = 6'd0;
            tick_d  = 1'b1;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + 6'd1;
         end
      end
   end

`ifdef J_CLKDIV_SHADOW_EN
   logic [5:0] shadow_q;
   logic [5:0] shadow_d;
   logic       load_ratio;

   // Transfer at a period boundary, or while idle at count zero; always takes the old shadow.
   assign load_ratio = en ? (overrun || wrap) : (cnt_q == 6'd0);

   always_comb begin
      shadow_d = wr ? din : shadow_q;
      ratio_d  = load_ratio ? shadow_q : ratio_q;
   end

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         shadow_q <= RESET_RATIO;
      end else begin
         shadow_q <= shadow_d;
      end
   end
`else
   always_comb begin
      ratio_d = wr ? din : ratio_q;
   end
`endif

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         cnt_q   <= 6'd0;
         ratio_q <= RESET_RATIO;
         tick_q  <= 1'b0;
         phase_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         ratio_q <= ratio_d;
         tick_q  <= tick_d;
         phase_q <= phase_d;
         ovr_q   <= ovr_d;
      end
   end

   assign cnt   = cnt_q;
   assign ratio = ratio_q;
   assign tick  = tick_q;
   assign phase = phase_q;
   assign ovr   = ovr_q;

endmodule

// File: tb/tb_j_clkdiv_cnt.sv
// Testbench for j_clkdiv_cnt: randomized and directed stimulus against a cycle-level rule model.
// Follows the DUT build option J_CLKDIV_SHADOW_EN when it is defined.
module tb_j_clkdiv_cnt;

   logic       clk = 1'b0;
   logic       resetl = 1'b0;
   logic       en = 1'b0;
   logic       wr = 1'b0;
   logic [5:0] din = 6'd0;
   logic [5:0] cnt;
   logic [5:0] ratio;
   logic       tick;
   logic       phase;
   logic       ovr;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];

   logic [5:0] m_cnt;
   logic [5:0] m_ratio;
   logic       m_tick;
   logic       m_phase;
   logic       m_ovr;
`ifdef J_CLKDIV_SHADOW_EN
   logic [5:0] m_shadow;
`endif

   j_clkdiv_cnt dut (
      .clk    (clk),
      .resetl (resetl),
      .en     (en),
      .wr     (wr),
      .din    (din),
      .cnt    (cnt),
      .ratio  (ratio),
      .tick   (tick),
      .phase  (phase),
      .ovr    (ovr)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] dut_vec();
      return {cnt, ratio, tick, phase, ovr};
   endfunction

   function automatic logic [14:0] mdl_vec();
      return {m_cnt, m_ratio, m_tick, m_phase, m_ovr};
   endfunction

   task automatic model_reset();
      m_cnt   = 6'd0;
      m_ratio = 6'd63;
      m_tick  = 1'b0;
      m_phase = 1'b0;
      m_ovr   = 1'b0;
`ifdef J_CLKDIV_SHADOW_EN
      m_shadow = 6'd63;
`endif
   endtask

   task automatic model_edge(input logic e, input logic w, input logic [5:0] d);
      logic       over;
      logic       wrp;
      logic [5:0] nr;
      over = (m_cnt > m_ratio);
      wrp  = (m_cnt == m_ratio);
      nr   = m_ratio;
`ifdef J_CLKDIV_SHADOW_EN
      if ((e && (over || wrp)) || (!e && m_cnt == 6'd0)) nr = m_shadow;
      if (w) m_shadow = d;
`else
      if (w) nr = d;
`endif
      m_tick = 1'b0;
      m_ovr  = 1'b0;
      if (e) begin
         if (over) begin
            m_cnt = 6'd0;
            m_ovr = 1'b1;
         end else if (wrp) begin
            m_cnt   = 6'd0;
            m_tick  = 1'b1;
            m_phase = ~m_phase;
         end else begin
            m_cnt = m_cnt + 6'd1;
         end
      end
      m_ratio = nr;
   endtask

   // Driver: present inputs, take one edge, advance the model, log tick times.
   task automatic drive(input logic e, input logic w, input logic [5:0] d);
      en  = e;
      wr  = w;
      din = d;
      @(posedge clk);
      model_edge(e, w, d);
      cyc++;
      #1;
      if (tick === 1'b1) obs_q.push_back(cyc);
      wr = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      resetl = 1'b0;
      en     = 1'b0;
      wr     = 1'b0;
      din    = 6'd0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      resetl = 1'b1;
      cyc = 0;
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (dut_vec() !== {6'd0, 6'd63, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", dut_vec(), {6'd0, 6'd63, 3'b000});
      end
   endtask

   task automatic test_default_ratio();
      int ovr_seen;
      ovr_seen = 0;
      apply_reset();
      exp_q.push_back(32'd64);
      exp_q.push_back(32'd128);
      for (int i = 1; i <= 130; i++) begin
         drive(1'b1, 1'b0, 6'd0);
         if (ovr === 1'b1) ovr_seen++;
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL default_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), mdl_vec());
         end
         if (i == 64 || i == 128) begin
            checks++;
            if (phase !== ((i == 64) ? 1'b1 : 1'b0)) begin
               errors++;
               $display("FAIL default_phase cyc=%0d got=%b exp=%b", cyc, phase, (i == 64));
            end
         end
      end
      checks++;
      if (ovr_seen != 0) begin
         errors++;
         $display("FAIL default_ovr got=%0d pulses exp=0", ovr_seen);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL default_ticks count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
               errors++;
               $display("FAIL default_tick_time got=%0d exp=%0d", obs_q[k], exp_q[k]);
            end
         end
      end
   endtask

   task automatic test_ratio3();
      int base;
      apply_reset();
      drive(1'b0, 1'b1, 6'd3);
      drive(1'b0, 1'b0, 6'd0);
      base = cyc;
      obs_q.delete();
      for (int t = 4; t <= 16; t += 4) exp_q.push_back(32'(base + t));
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 1'b0, 6'd0);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL ratio3_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), mdl_vec());
         end
         checks++;
         if (cnt !== 6'(i % 4) || phase !== 1'((i / 4) % 2)) begin
            errors++;
            $display("FAIL ratio3_seq i=%0d got cnt=%0d phase=%b exp cnt=%0d phase=%0d",
                     i, cnt, phase, i % 4, (i / 4) % 2);
         end
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL ratio3_ticks count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
               errors++;
               $display("FAIL ratio3_tick_time got=%0d exp=%0d", obs_q[k], exp_q[k]);
            end
         end
      end
   endtask

   task automatic test_ratio0();
      apply_reset();
      drive(1'b0, 1'b1, 6'd0);
      drive(1'b0, 1'b0, 6'd0);
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 1'b0, 6'd0);
         checks++;
         if (tick !== 1'b1 || cnt !== 6'd0 || phase !== 1'(i % 2)) begin
            errors++;
            $display("FAIL ratio0_run i=%0d got tick=%b cnt=%0d phase=%b exp tick=1 cnt=0 phase=%0d",
                     i, tick, cnt, phase, i % 2);
         end
      end
      for (int i = 1; i <= 5; i++) begin
         drive(1'b0, 1'b0, 6'd0);
         checks++;
         if (tick !== 1'b0 || phase !== 1'b1 || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL ratio0_hold i=%0d got=%h exp=%h (tick=0 phase=1)", i, dut_vec(), mdl_vec());
         end
      end
   endtask

   task automatic test_overrun();
      int base;
      int ovr_seen;
      ovr_seen = 0;
      apply_reset();
      drive(1'b0, 1'b1, 6'd20);
      drive(1'b0, 1'b0, 6'd0);
      for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 6'd0);
      checks++;
      if (cnt !== 6'd15 || ratio !== 6'd20) begin
         errors++;
         $display("FAIL overrun_setup got cnt=%0d ratio=%0d exp cnt=15 ratio=20", cnt, ratio);
      end
      drive(1'b1, 1'b1, 6'd5);
      base = cyc;
      obs_q.delete();
`ifdef J_CLKDIV_SHADOW_EN
      exp_q.push_back(32'(base + 5));
      exp_q.push_back(32'(base + 11));
      exp_q.push_back(32'(base + 17));
`else
      exp_q.push_back(32'(base + 7));
      exp_q.push_back(32'(base + 13));
`endif
      for (int i = 1; i <= 18; i++) begin
         drive(1'b1, 1'b0, 6'd0);
         if (ovr === 1'b1) ovr_seen++;
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL overrun_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), mdl_vec());
         end
`ifndef J_CLKDIV_SHADOW_EN
         if (i == 1) begin
            checks++;
            if (dut_vec() !== {6'd0, 6'd5, 1'b0, 1'b0, 1'b1}) begin
               errors++;
               $display("FAIL overrun_recover got=%h exp=%h", dut_vec(), {6'd0, 6'd5, 3'b001});
            end
         end
`endif
      end
      checks++;
`ifdef J_CLKDIV_SHADOW_EN
      if (ovr_seen != 0) begin
         errors++;
         $display("FAIL overrun_pulses got=%0d exp=0", ovr_seen);
      end
`else
      if (ovr_seen != 1) begin
         errors++;
         $display("FAIL overrun_pulses got=%0d exp=1", ovr_seen);
      end
`endif
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL overrun_ticks count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
               errors++;
               $display("FAIL overrun_tick_time got=%0d exp=%0d", obs_q[k], exp_q[k]);
            end
         end
      end
   endtask

   task automatic test_wr_wrap();
      int base;
      apply_reset();
      drive(1'b0, 1'b1, 6'd3);
      drive(1'b0, 1'b0, 6'd0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 6'd0);
      base = cyc;
      obs_q.delete();
      exp_q.push_back(32'(base + 1));
`ifdef J_CLKDIV_SHADOW_EN
      exp_q.push_back(32'(base + 5));
      exp_q.push_back(32'(base + 13));
      exp_q.push_back(32'(base + 21));
`else
      exp_q.push_back(32'(base + 9));
      exp_q.push_back(32'(base + 17));
`endif
      drive(1'b1, 1'b1, 6'd7);
      for (int i = 2; i <= 21; i++) begin
         drive(1'b1, 1'b0, 6'd0);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL wr_wrap_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), mdl_vec());
         end
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL wr_wrap_ticks count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
               errors++;
               $display("FAIL wr_wrap_tick_time got=%0d exp=%0d", obs_q[k], exp_q[k]);
            end
         end
      end
   endtask

   task automatic test_reset_midcount();
      apply_reset();
      drive(1'b0, 1'b1, 6'd9);
      drive(1'b0, 1'b0, 6'd0);
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 6'd0);
      checks++;
      if (cnt !== 6'd7 || ratio !== 6'd9) begin
         errors++;
         $display("FAIL midreset_setup got cnt=%0d ratio=%0d exp cnt=7 ratio=9", cnt, ratio);
      end
      #2;
      resetl = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_vec() !== {6'd0, 6'd63, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL midreset_async got=%h exp=%h", dut_vec(), {6'd0, 6'd63, 3'b000});
      end
      @(posedge clk);
      #1;
      checks++;
      if (dut_vec() !== {6'd0, 6'd63, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL midreset_hold got=%h exp=%h", dut_vec(), {6'd0, 6'd63, 3'b000});
      end
      @(negedge clk);
      resetl = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 1'b0, 6'd0);
         checks++;
         if (dut_vec() !== mdl_vec() || cnt !== 6'(i)) begin
            errors++;
            $display("FAIL midreset_resume i=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
         end
      end
   endtask

   task automatic test_random();
      logic       e;
      logic       w;
      logic [5:0] d;
      apply_reset();
      for (int i = 0; i < 800; i++) begin
         e = ($urandom_range(0, 3) != 0);
         w = ($urandom_range(0, 11) == 0);
         d = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 12)) : 6'($urandom_range(0, 63));
         drive(e, w, d);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL random_model cyc=%0d en=%b wr=%b din=%0d got=%h exp=%h",
                     cyc, e, w, d, dut_vec(), mdl_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_default_ratio();
      test_ratio3();
      test_ratio0();
      test_overrun();
      test_wr_wrap();
      test_reset_midcount();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
